// File: rtl/fetch_sequencer.sv
// PC sequencing and instruction fetch for the pipelined LEGv8 core.
// Optional FETCH_PERF_CNT_EN adds stall-cycle and redirect counters.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cyc,
    output logic [31:0]        perf_redirects
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } state_e;

    typedef struct packed {
        logic               v;
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    ifid_t             ifid_q, ifid_d;
    ifid_t             skid_q, skid_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_tgt;
    ifid_t             fetched;

    assign pc_inc  = pc_q + ADDR_W'(4);
    assign br_tgt  = br_target & ~ADDR_W'(3);
    assign fetched = {1'b1, pc_q, imem_rdata};

    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_valid  = ifid_q.v;
    assign if_pc     = ifid_q.pc;
    assign if_instr  = ifid_q.instr;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ifid_d  = ifid_q;
        skid_d  = skid_q;
        if (br_taken) begin
            ifid_d.v = 1'b0;
            skid_d.v = 1'b0;
            // An unacked request must complete at its original address
            if (imem_req && !imem_ack) begin
                tgt_d   = br_tgt;
                state_d = DRAIN;
            end else begin
                pc_d    = br_tgt;
                state_d = REQ;
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (stall && ifid_q.v) begin
                            skid_d  = fetched;
                            state_d = HOLD;
                        end else begin
                            ifid_d = fetched;
                        end
                    end else if (!stall) begin
                        ifid_d.v = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_d   = skid_q;
                        skid_d.v = 1'b0;
                        state_d  = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc_d    = tgt_q;
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            ifid_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            ifid_q  <= ifid_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        stall_cyc_d = stall_cyc_q;
        redirects_d = redirects_q;
        if (stall && ifid_q.v && (stall_cyc_q != '1))
            stall_cyc_d = stall_cyc_q + 32'd1;
        if (br_taken && (redirects_q != '1))
            redirects_d = redirects_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cyc_q <= '0;
            redirects_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            redirects_q <= redirects_d;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a random run
// scored against an in-order instruction stream model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [63:0] pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] rd_xor = '0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_redirects;
`endif

    int pass_cnt = 0;
    int tot_cnt = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address
    assign imem_rdata = imem_addr[31:0] ^ rd_xor;

    fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_redirects(perf_redirects)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1;
        stall = 1'($urandom);
        br_taken = 1'b1;
        br_target = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        tot_cnt++;
        if ({pc, imem_req, if_valid, if_pc, if_instr} !==
            {64'h0, 1'b0, 1'b0, 64'h0, 32'h0})
            $display("FAIL reset: got pc=%h req=%b v=%b ifpc=%h instr=%h want zeros",
                     pc, imem_req, if_valid, if_pc, if_instr);
        else pass_cnt++;
        reset = 1'b0;
        imem_ack = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack = 1'b1;
        tot_cnt++;
        if (imem_req !== 1'b0)
            $display("FAIL idle_cycle: got req=%b want 0", imem_req);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({imem_req, if_valid, imem_addr} !== {1'b1, 1'b0, 64'h0})
            $display("FAIL first_req: got req=%b v=%b addr=%h want 1 0 0",
                     imem_req, if_valid, imem_addr);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tot_cnt++;
            if ({if_valid, if_pc, if_instr, imem_addr} !==
                {1'b1, 64'(k * 4), 32'(k * 4), 64'(k * 4 + 4)})
                $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h addr=%h want pc=%h",
                         k, if_valid, if_pc, if_instr, imem_addr, 64'(k * 4));
            else pass_cnt++;
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_slow_ack();
        do_reset();
        imem_ack = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                tot_cnt++;
                if ({imem_req, imem_addr} !== {1'b1, 64'(w * 4)})
                    $display("FAIL slow_addr[%0d.%0d]: got req=%b addr=%h want 1 %h",
                             w, c, imem_req, imem_addr, 64'(w * 4));
                else pass_cnt++;
                tot_cnt++;
                if (if_valid !== ((c == 0) && (w > 0)))
                    $display("FAIL slow_pulse[%0d.%0d]: got v=%b", w, c, if_valid);
                else pass_cnt++;
                if ((c == 0) && (w > 0)) begin
                    tot_cnt++;
                    if (if_pc !== 64'((w - 1) * 4))
                        $display("FAIL slow_pc[%0d]: got %h want %h",
                                 w, if_pc, 64'((w - 1) * 4));
                    else pass_cnt++;
                end
                imem_ack = (c == 2);
                @(negedge clk);
            end
        end
        imem_ack = 1'b0;
        tot_cnt++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 64'h8, 32'h8})
            $display("FAIL slow_last: got v=%b pc=%h instr=%h want 1 8 8",
                     if_valid, if_pc, if_instr);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if ({if_pc, imem_addr} !== {64'h4, 64'h8})
            $display("FAIL stall_pre: got pc=%h addr=%h want 4 8", if_pc, imem_addr);
        else pass_cnt++;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tot_cnt++;
            if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 64'h4, 32'h4})
                $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h instr=%h want 0 1 4 4",
                         i, imem_req, if_valid, if_pc, if_instr);
            else pass_cnt++;
        end
        stall = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !==
            {1'b1, 64'h8, 32'h8, 1'b1, 64'hC})
            $display("FAIL stall_skid: got v=%b pc=%h instr=%h req=%b addr=%h want 1 8 8 1 c",
                     if_valid, if_pc, if_instr, imem_req, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 64'hC, 32'hC, 64'h10})
            $display("FAIL stall_resume: got v=%b pc=%h instr=%h addr=%h want 1 c c 10",
                     if_valid, if_pc, if_instr, imem_addr);
        else pass_cnt++;
        imem_ack = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if (imem_addr !== 64'h8)
            $display("FAIL drain_pre: got addr=%h want 8", imem_addr);
        else pass_cnt++;
        imem_ack = 1'b0;
        br_taken = 1'b1;
        br_target = 64'h103;
        @(negedge clk);
        br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tot_cnt++;
            if ({imem_req, if_valid, imem_addr} !== {1'b1, 1'b0, 64'h8})
                $display("FAIL drain_hold[%0d]: got req=%b v=%b addr=%h want 1 0 8",
                         i, imem_req, if_valid, imem_addr);
            else pass_cnt++;
            imem_ack = (i == 1);
            @(negedge clk);
        end
        tot_cnt++;
        if ({imem_req, if_valid, imem_addr} !== {1'b1, 1'b0, 64'h100})
            $display("FAIL drain_redirect: got req=%b v=%b addr=%h want 1 0 100",
                     imem_req, if_valid, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 64'h100, 32'h100})
            $display("FAIL drain_word: got v=%b pc=%h instr=%h want 1 100 100",
                     if_valid, if_pc, if_instr);
        else pass_cnt++;
        imem_ack = 1'b0;
    endtask

    task automatic test_br_skid();
        do_reset();
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if ({imem_req, if_pc} !== {1'b0, 64'h4})
            $display("FAIL brskid_hold: got req=%b pc=%h want 0 4", imem_req, if_pc);
        else pass_cnt++;
        br_taken = 1'b1;
        br_target = 64'h200;
        @(negedge clk);
        br_taken = 1'b0;
        tot_cnt++;
        if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h200})
            $display("FAIL brskid_flush: got v=%b req=%b addr=%h want 0 1 200",
                     if_valid, imem_req, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 64'h200, 32'h200, 64'h204})
            $display("FAIL brskid_load: got v=%b pc=%h instr=%h addr=%h want 1 200 200 204",
                     if_valid, if_pc, if_instr, imem_addr);
        else pass_cnt++;
        stall = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc} !== {1'b1, 64'h204})
            $display("FAIL brskid_next: got v=%b pc=%h want 1 204", if_valid, if_pc);
        else pass_cnt++;
        imem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack = 1'b1;
        @(negedge clk);
        br_taken = 1'b1;
        br_target = '1;
        @(negedge clk);
        br_taken = 1'b0;
        tot_cnt++;
        if ({if_valid, imem_addr} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFC})
            $display("FAIL wrap_tgt: got v=%b addr=%h want 0 fffffffffffffffc",
                     if_valid, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc, if_instr, imem_addr} !==
            {1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 64'h0})
            $display("FAIL wrap_pc: got v=%b pc=%h instr=%h addr=%h want wrap to 0",
                     if_valid, if_pc, if_instr, imem_addr);
        else pass_cnt++;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_drain();
        do_reset();
        imem_ack = 1'b0;
        @(negedge clk);
        br_taken = 1'b1;
        br_target = 64'h40;
        @(negedge clk);
        br_taken = 1'b0;
        tot_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h0})
            $display("FAIL rstdrain_pre: got req=%b addr=%h want 1 0", imem_req, imem_addr);
        else pass_cnt++;
        reset = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if ({pc, imem_req, if_valid, if_pc, if_instr} !==
            {64'h0, 1'b0, 1'b0, 64'h0, 32'h0})
            $display("FAIL rstdrain_rst: got pc=%h req=%b v=%b ifpc=%h instr=%h want zeros",
                     pc, imem_req, if_valid, if_pc, if_instr);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
        tot_cnt++;
        if ({imem_req, if_valid, imem_addr} !== {1'b1, 1'b0, 64'h0})
            $display("FAIL rstdrain_late_ack: got req=%b v=%b addr=%h want 1 0 0",
                     imem_req, if_valid, imem_addr);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({if_valid, if_pc} !== {1'b1, 64'h0})
            $display("FAIL rstdrain_resume: got v=%b pc=%h want 1 0", if_valid, if_pc);
        else pass_cnt++;
        imem_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] prev_addr;
        logic        prev_pend;
        int          consumed;
        int          n_stall;
        int          n_br;
        do_reset();
        rd_xor = 32'h5A5A_0000;
        exp_pc = '0;
        prev_pend = 1'b0;
        prev_addr = '0;
        consumed = 0;
        n_stall = 0;
        n_br = 0;
        for (int i = 0; i < 3000; i++) begin
            if (prev_pend) begin
                tot_cnt++;
                if ({imem_req, imem_addr} !== {1'b1, prev_addr})
                    $display("FAIL rand_handshake[%0d]: got req=%b addr=%h want 1 %h",
                             i, imem_req, imem_addr, prev_addr);
                else pass_cnt++;
            end
            imem_ack = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                br_target = 64'($urandom_range(0, 4095));
            else
                br_target = {$urandom, $urandom};
            if (stall && if_valid) n_stall++;
            if (br_taken) n_br++;
            // The consumer takes IF/ID on any unstalled, unflushed edge
            if (br_taken) begin
                exp_pc = br_target & ~64'h3;
            end else if (if_valid && !stall) begin
                tot_cnt++;
                if ({if_pc, if_instr} !== {exp_pc, exp_pc[31:0] ^ rd_xor})
                    $display("FAIL rand_stream[%0d]: got pc=%h instr=%h want %h %h",
                             i, if_pc, if_instr, exp_pc, exp_pc[31:0] ^ rd_xor);
                else pass_cnt++;
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
        tot_cnt++;
        if (consumed < 300)
            $display("FAIL rand_progress: got %0d words want at least 300", consumed);
        else pass_cnt++;
`ifdef FETCH_PERF_CNT_EN
        tot_cnt++;
        if ({perf_stall_cyc, perf_redirects} !== {32'(n_stall), 32'(n_br)})
            $display("FAIL rand_perf: got %0d %0d want %0d %0d",
                     perf_stall_cyc, perf_redirects, n_stall, n_br);
        else pass_cnt++;
`endif
        rd_xor = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_slow_ack();
        test_stall();
        test_drain();
        test_br_skid();
        test_wrap();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program counter and instruction-memory fetch for the pipelined LEGv8 core.
- Issues fetch requests over a req/ack handshake and advances PC by 4 on each accepted word.
- Redirects on taken branches and flushes wrong-path fetches.
- Honours downstream stalls through a one-entry skid buffer. Drives the IF/ID register fields (if_valid, if_pc, if_instr).

Parameters:
ADDR_W, 64, PC / address width
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
imem_req  output  1  fetch request; held until imem_ack
imem_addr  output  ADDR_W  fetch address; stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0
imem_rdata  input  INSTR_W  instruction word, valid with imem_ack
stall  input  1  IF/ID must hold (hazard unit)
br_taken  input  1  one-cycle redirect strobe from EX/MEM
br_target  input  ADDR_W  redirect address, bits [1:0] forced to 0
pc  output  ADDR_W  address of next fetch
if_valid  output  1  IF/ID holds a valid instruction
if_pc  output  ADDR_W  address of if_instr
if_instr  output  INSTR_W  fetched instruction

Behaviour:
- Reset (any state, including with an outstanding request): next edge gives pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=0, skid empty, state=IDLE. Ack arriving during reset is dropped.
- imem_addr = pc at all times. pc wraps modulo 2^ADDR_W.
- States:
  - IDLE: imem_req=0. Next edge goes to REQ (one dead cycle after reset).
  - REQ: imem_req=1. Ack may be combinational (same cycle as req), giving 1 fetch/cycle.
    - ack & !stall: next edge loads if_instr=rdata, if_pc=pc, if_valid=1, pc+=4. Stay in REQ (back-to-back request).
    - ack & stall & if_valid: rdata/pc go to skid, pc+=4, go to HOLD.
    - ack & stall & !if_valid: load IF/ID directly, as in the !stall case.
    - no ack: pc holds. If !stall, if_valid<=0.
  - HOLD: imem_req=0, IF/ID and skid frozen. When stall=0, next edge moves skid to IF/ID (if_valid=1), empties skid, goes to REQ.
  - DRAIN: imem_req=1, address unchanged (stale request). On ack, discard rdata, load pc=pending target, go to REQ. if_valid stays 0.
- br_taken (highest priority, overrides stall):
  - Next edge: if_valid=0, skid emptied.
  - Request outstanding without ack this cycle: latch target as pending, go to DRAIN.
  - Otherwise: pc=target, go to REQ.
  - br_taken during DRAIN: replaces the pending target.
- No instruction is ever lost or duplicated. if_pc sequence is strictly +4 except across a redirect.
- Handshake rule: imem_req never drops and imem_addr never changes before ack.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_stall_cyc (32) and perf_redirects (32), both saturating at 0xFFFFFFFF and cleared on reset.
  - perf_stall_cyc: +1 each cycle stall=1 && if_valid=1.
  - perf_redirects: +1 per br_taken cycle.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, imem_ack tied 1, rdata=addr[31:0] -> IDLE one cycle; if_pc=0,4,8,... on consecutive cycles starting cycle 2; if_instr=if_pc.
- ack delayed 3 cycles per fetch -> imem_addr=0x0 stable for 3 cycles with imem_req=1; if_valid single-cycle pulse per word; pc 0->4 only after ack.
- stall=1 for 2 cycles while ack=1 -> if_instr held at word 0x4, skid holds 0x8, imem_req=0 in HOLD; after release if_pc continues 0x8,0xC with no gap or duplicate.
- Request to 0x8 outstanding, br_taken target 0x103, ack 2 cycles later -> DRAIN; stale word discarded; next imem_addr=0x100; if_valid=0 until 0x100 word arrives.
- br_taken target 0x200 with stall=1 and skid full -> next cycle if_valid=0, skid empty, imem_addr=0x200.
- reset asserted while in DRAIN with ack pending -> next edge all outputs at reset values, pc=RESET_PC; late ack ignored.
